kdf_feedback_ctrl: RTL
======================

# kdf_feedback_ctrl

Sequencer that runs the SHA256 core in SP800-108 feedback mode to derive up to MAX_ITER×256 bits of key material. For each iteration i it builds one pre-padded 512-bit block, K(i-1) || [i]32 || FixedInfo || [L]32 || pad, and streams it into the core. It then collects the 256-bit digest into a feedback register and emits the requested words on a valid/ready stream. The block sits between the key-generation top level and the SHA256 core; the top level ties sha_wdata/sha_rdata to the core's bidirectional data bus.

## Interface
- MAX_ITER, 16, maximum iterations; L is limited to 256×MAX_ITER bits
- EOC_TIMEOUT, 255, cycles allowed between the last loaded word and sha_eoc before err
- clk  in  1  clock, all flops rising edge
- rst  in  1  reset; asynchronous and active-high
- start  in  1  one-cycle request, sampled only in IDLE
- iv  in  256  K(0); word 0 = iv[255:224]
- fixed_info  in  96  Label||0x00||Context, message words 9..11, MSW first
- out_len  in  16  L in bits, captured at start
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse at completion, including on err
- err  out  1  sticky until next accepted start; set on L=0, L>256×MAX_ITER, or eoc timeout
- key_word  out  32  output key word
- key_valid  out  1  key_word valid
- key_last  out  1  with key_valid on the final word
- key_ready  in  1  consumer accept
- sha_soc  out  1  core start-of-computation pulse
- sha_wdata  out  32  message word to core
- sha_rd  out  1  core read strobe
- sha_eoc  in  1  core end-of-computation
- sha_rdata  in  32  digest word from core

## Operation
- States: IDLE, LOAD, WAIT, READ, EMIT, FIN.
- IDLE: on start, latch iv into fb[0..7], latch fixed_info and out_len, set i=1, nwords=ceil(L/32), clear err. If L=0 or L>256×MAX_ITER, set err and go to FIN. Otherwise go to LOAD.
- LOAD: 16 cycles, j=0..15. sha_wdata = msg[j] and sha_soc=1 only at j=0.
  - msg[0..7] = fb[0..7]; msg[8] = i; msg[9..11] = fixed_info.
  - msg[12] = {16'h0, L}; msg[13] = 32'h80000000; msg[14] = 0; msg[15] = 32'h000001A0 (416-bit message).
- WAIT: hold until sha_eoc=1, then go to READ. If the wait counter reaches EOC_TIMEOUT, set err and go to FIN.
- READ: 8 cycles with sha_rd=1; fb[j] <= sha_rdata in cycle j.
- EMIT: present fb[w] for w=0..7. A word transfers when key_valid&&key_ready, and the remaining-word counter decrements on each transfer.
  - When the remaining count reaches 0, go to FIN; the last word carries key_last.
  - Otherwise, after w=7: i++ and go to LOAD. fb now holds K(i), which is the feedback for the next block.
- FIN: done=1 for one cycle, then IDLE.
- Arithmetic: i is 32-bit and never wraps (bounded by MAX_ITER). nwords is 12-bit with round-up; a partial final word is emitted whole, and truncation is the consumer's job.

## Timing
- Reset values: busy=0, done=0, err=0, key_valid=0, key_last=0, key_word=0, sha_soc=0, sha_rd=0, sha_wdata=0, state=IDLE, fb=0.
- All outputs are registered except key_word and key_valid, which are decoded from the state and fb.
- Start to first sha_soc: 1 cycle.
- Each iteration costs 16 (LOAD) + core latency + 8 (READ) cycles, plus the EMIT cycles.
- The key stream follows standard valid/ready rules:
  - key_word and key_last stay stable while key_valid=1 and key_ready=0.
  - key_ready has no effect on the core.
- start during busy is ignored. sha_eoc outside WAIT is ignored.
- rst mid-operation aborts immediately with no done pulse.

## Structure
- Package kdf_pkg holds:
  - the state enum;
  - constants PAD_WORD=32'h80000000, MSG_BITS=32'h000001A0, LOAD_WORDS=16, DIGEST_WORDS=8.
- Sub-module kdf_msg_mux: combinational msg[j] select from j, fb, i, fixed_info and L.

## Test plan
- iv=0, fixed_info=96'h4C4142454C00434F4E544558, L=256, key_ready=1. Required: 16 words with word 13=80000000, word 15=000001A0, word 8=1; then 8 key words equal to a software SHA256 of the 52-byte message; key_last on word 8; one done.
- L=600: 3 iterations with word 8 = 1, 2, 3; block 2 words 0..7 equal digest 1; 19 words emitted; key_last on word 19.
- key_ready toggles 1-0-0-1 during EMIT: key_word stays stable while stalled, no word lost or duplicated, sha_soc for the next iteration only after word 8 transfers.
- L=0 and L=4097 (MAX_ITER=16): err=1 and done pulse 2 cycles after start, no sha_soc.
- sha_eoc held 0: err and done after EOC_TIMEOUT cycles in WAIT; the next start clears err.
- rst asserted during READ: all outputs return to reset values asynchronously; a new start then runs a clean iteration 1.

Source files
------------

// File: rtl/kdf_pkg.sv
// Shared types and constants for the SP800-108 feedback-mode KDF sequencer.
package kdf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_WAIT = 3'd2,
    ST_READ = 3'd3,
    ST_EMIT = 3'd4,
    ST_FIN  = 3'd5
  } kdf_state_e;

  localparam logic [31:0] PAD_WORD     = 32'h8000_0000;
  localparam logic [31:0] MSG_BITS     = 32'h0000_01A0;
  localparam int          LOAD_WORDS   = 16;
  localparam int          DIGEST_WORDS = 8;

  // Bit offset of 32-bit word k in a 256-bit vector where word 0 is the MSW.
  function automatic logic [7:0] word_lsb(input logic [2:0] k);
    return 8'd224 - {k, 5'd0};
  endfunction

endpackage

// File: rtl/kdf_msg_mux.sv
// Selects message word idx of the pre-padded 512-bit feedback-mode block.
module kdf_msg_mux
  import kdf_pkg::*;
(
  input  logic [3:0]   idx,
  input  logic [255:0] fb,
  input  logic [31:0]  iter,
  input  logic [95:0]  fixed_info,
  input  logic [15:0]  out_len,
  output logic [31:0]  word
);

  always_comb begin
    word = 32'h0;
    case (idx)
      4'd8:    word = iter;
      4'd9:    word = fixed_info[95:64];
      4'd10:   word = fixed_info[63:32];
      4'd11:   word = fixed_info[31:0];
      4'd12:   word = {16'h0, out_len};
      4'd13:   word = PAD_WORD;
      4'd14:   word = 32'h0;
      4'd15:   word = MSG_BITS;
      default: word = fb[word_lsb(idx[2:0]) +: 32];
    endcase
  end

endmodule

// File: rtl/kdf_feedback_ctrl.sv
// Runs the SHA256 core in SP800-108 feedback mode: load block, await digest,
// read it back as the next feedback value, and stream the key words out.
module kdf_feedback_ctrl
  import kdf_pkg::*;
#(
  parameter int MAX_ITER    = 16,
  parameter int EOC_TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] iv,
  input  logic [95:0]  fixed_info,
  input  logic [15:0]  out_len,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [31:0]  key_word,
  output logic         key_valid,
  output logic         key_last,
  input  logic         key_ready,
  output logic         sha_soc,
  output logic [31:0]  sha_wdata,
  output logic         sha_rd,
  input  logic         sha_eoc,
  input  logic [31:0]  sha_rdata
);

  localparam int                WCNT_W    = $clog2(EOC_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(EOC_TIMEOUT - 1);
  localparam logic [16:0]       MAX_LEN   = 17'(256 * MAX_ITER);

  kdf_state_e        state_q, state_d;
  logic [3:0]        j_q, j_d;
  logic [31:0]       i_q, i_d;
  logic [11:0]       rem_q, rem_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [255:0]      fb_q, fb_d;
  logic [95:0]       fixed_q, fixed_d;
  logic [15:0]       len_q, len_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic              last_q, last_d, soc_q, soc_d, rd_q, rd_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       msg_s;
  logic [16:0]       len_sum_s;
  logic [11:0]       nwords_s;
  logic              len_bad_s;

  assign len_bad_s = (out_len == 16'd0) || ({1'b0, out_len} > MAX_LEN);
  assign len_sum_s = {1'b0, out_len} + 17'd31;
  assign nwords_s  = 12'(len_sum_s >> 5);

  // The mux sees next-state values so sha_wdata can be registered in step with LOAD.
  kdf_msg_mux u_msg_mux (
    .idx        (j_d),
    .fb         (fb_d),
    .iter       (i_d),
    .fixed_info (fixed_d),
    .out_len    (len_d),
    .word       (msg_s)
  );

  // Next-state and registered-output decode.
  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    i_d     = i_q;
    rem_d   = rem_q;
    wcnt_d  = wcnt_q;
    fb_d    = fb_q;
    fixed_d = fixed_q;
    len_d   = len_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          fb_d    = iv;
          fixed_d = fixed_info;
          len_d   = out_len;
          i_d     = 32'd1;
          rem_d   = nwords_s;
          j_d     = 4'd0;
          err_d   = len_bad_s;
          state_d = len_bad_s ? ST_FIN : ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (j_q == 4'(LOAD_WORDS - 1)) begin
          wcnt_d  = '0;
          state_d = ST_WAIT;
        end else begin
          j_d = j_q + 4'd1;
        end
      end
      ST_WAIT: begin
        if (sha_eoc) begin
          j_d     = 4'd0;
          state_d = ST_READ;
        end else if (wcnt_q == WCNT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_FIN;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      ST_READ: begin
        fb_d[word_lsb(j_q[2:0]) +: 32] = sha_rdata;
        if (j_q == 4'(DIGEST_WORDS - 1)) begin
          j_d     = 4'd0;
          state_d = ST_EMIT;
        end else begin
          j_d = j_q + 4'd1;
        end
      end
      ST_EMIT: begin
        if (key_ready) begin
          rem_d = rem_q - 12'd1;
          if (rem_q == 12'd1) begin
            state_d = ST_FIN;
          end else if (j_q == 4'(DIGEST_WORDS - 1)) begin
            i_d     = i_q + 32'd1;
            j_d     = 4'd0;
            state_d = ST_LOAD;
          end else begin
            j_d = j_q + 4'd1;
          end
        end else begin
          state_d = ST_EMIT;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    soc_d   = (state_d == ST_LOAD) && (state_q != ST_LOAD);
    wdata_d = (state_d == ST_LOAD) ? msg_s : 32'h0;
    rd_d    = (state_d == ST_READ);
    done_d  = (state_q == ST_FIN);
    busy_d  = (state_d != ST_IDLE);
    last_d  = (state_d == ST_EMIT) && (rem_d == 12'd1);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      j_q     <= 4'd0;
      i_q     <= 32'd0;
      rem_q   <= 12'd0;
      wcnt_q  <= '0;
      fb_q    <= 256'h0;
      fixed_q <= 96'h0;
      len_q   <= 16'h0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
      soc_q   <= 1'b0;
      rd_q    <= 1'b0;
      wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      i_q     <= i_d;
      rem_q   <= rem_d;
      wcnt_q  <= wcnt_d;
      fb_q    <= fb_d;
      fixed_q <= fixed_d;
      len_q   <= len_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      last_q  <= last_d;
      soc_q   <= soc_d;
      rd_q    <= rd_d;
      wdata_q <= wdata_d;
    end
  end

  assign key_valid = (state_q == ST_EMIT);
  assign key_word  = key_valid ? fb_q[word_lsb(j_q[2:0]) +: 32] : 32'h0;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign key_last  = last_q;
  assign sha_soc   = soc_q;
  assign sha_rd    = rd_q;
  assign sha_wdata = wdata_q;

endmodule
